// File: rtl/ex_mem_pkg.sv
// Shared types for the EX/MEM stage: control bits, the registered bundle, alignment constant.
// Optional misaligned-target trap is enabled by EXMEM_MISALIGN_TRAP_EN in ex_mem_stage.
package ex_mem_pkg;

  localparam int XLEN = 32;
  localparam int REGW = 5;

  // Low target bits a jalr forces to zero before redirecting.
  localparam logic [1:0] REDIRECT_ALIGN_MASK = 2'b01;

  typedef struct packed {
    logic branch;
    logic jal;
    logic jalr;
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef struct packed {
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] wb;
    logic [REGW-1:0] rd;
    ctrl_t           ctrl;
    logic [2:0]      funct3;
  } exmem_bundle_t;

endpackage

// File: rtl/exmem_skid.sv
// Two-entry skid buffer (main + skid) with valid/ready on both sides and a synchronous flush.
// Handshake: a beat moves when valid & ready are both high at a rising edge; ready_o depends only on registered state.
module exmem_skid #(
  parameter type T = logic [7:0]
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic flush_i,
  input  logic wr_i,
  input  T     data_i,
  output logic ready_o,
  output logic valid_o,
  input  logic ready_i,
  output T     data_o
);

  logic main_valid_q, main_valid_d;
  logic skid_valid_q, skid_valid_d;
  T     main_q, main_d;
  T     skid_q, skid_d;
  logic consume;
  logic wr_ok;

  assign ready_o = ~skid_valid_q;
  assign valid_o = main_valid_q;
  assign data_o  = main_q;
  assign consume = main_valid_q & ready_i;
  assign wr_ok   = wr_i & ~skid_valid_q;

  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_d       = main_q;
    skid_d       = skid_q;
    if (flush_i) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (consume) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        skid_valid_d = 1'b0;
      end else if (wr_ok) begin
        main_d = data_i;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (wr_ok) begin
      // Main is held by a stalled consumer, so the new beat parks in skid.
      if (main_valid_q) begin
        skid_d       = data_i;
        skid_valid_d = 1'b1;
      end else begin
        main_d       = data_i;
        main_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_q       <= '0;
      skid_q       <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_q       <= main_d;
      skid_q       <= skid_d;
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM stage: branch/jump resolution, registered fetch redirect, writeback select and skid-buffered bundle to MEM.
// Define EXMEM_MISALIGN_TRAP_EN to trap (instead of redirect) on taken targets with bit 1 set.
module ex_mem_stage
  import ex_mem_pkg::*;
#(
  parameter int DATA_WIDTH = XLEN,
  parameter int REG_ADDR_W = REGW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] alu_result,
  input  logic [DATA_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0] imm,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [6:0]            ctrl,
  input  logic [2:0]            funct3,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_addr,
  output logic [DATA_WIDTH-1:0] out_wdata,
  output logic [DATA_WIDTH-1:0] out_wb,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic [6:0]            out_ctrl,
  output logic [2:0]            out_funct3,
`ifdef EXMEM_MISALIGN_TRAP_EN
  output logic                  misalign_trap,
  output logic [DATA_WIDTH-1:0] trap_pc,
`endif
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  input  logic                  flush
);

  ctrl_t                 c_in;
  logic                  taken;
  logic                  misalign;
  logic                  accept;
  logic                  wr;
  logic                  skid_ready;
  logic [DATA_WIDTH-1:0] jalr_sum;
  logic [DATA_WIDTH-1:0] target;
  logic [DATA_WIDTH-1:0] wb_val;
  exmem_bundle_t         b_in;
  exmem_bundle_t         b_out;

  logic                  redirect_valid_q, redirect_valid_d;
  logic [DATA_WIDTH-1:0] redirect_pc_q, redirect_pc_d;

  assign c_in     = ctrl_t'(ctrl);
  assign taken    = (c_in.branch & alu_result[0]) | c_in.jal | c_in.jalr;
  assign jalr_sum = rs1_data + imm;
  assign target   = c_in.jalr ? {jalr_sum[DATA_WIDTH-1:2], jalr_sum[1:0] & ~REDIRECT_ALIGN_MASK}
                              : pc + imm;
  assign wb_val   = (c_in.jal | c_in.jalr) ? pc + DATA_WIDTH'(4) : alu_result;

`ifdef EXMEM_MISALIGN_TRAP_EN
  assign misalign = taken & target[1];
`else
  assign misalign = 1'b0;
`endif

  // The cycle after a redirect is wrong-path: take whatever is offered and discard it.
  assign in_ready = redirect_valid_q | skid_ready;
  assign accept   = in_valid & in_ready;
  assign wr       = accept & ~redirect_valid_q & ~flush;

  always_comb begin
    b_in                = '0;
    b_in.addr           = alu_result;
    b_in.wdata          = rs2_data;
    b_in.wb             = wb_val;
    b_in.rd             = rd;
    b_in.ctrl           = c_in;
    b_in.ctrl.reg_write = c_in.reg_write & ~misalign;
    b_in.funct3         = funct3;
  end

  always_comb begin
    redirect_valid_d = wr & taken & ~misalign;
    redirect_pc_d    = redirect_valid_d ? target : redirect_pc_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= '0;
    end else begin
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
    end
  end

  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;

`ifdef EXMEM_MISALIGN_TRAP_EN
  logic                  trap_q;
  logic [DATA_WIDTH-1:0] trap_pc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      trap_q    <= 1'b0;
      trap_pc_q <= '0;
    end else begin
      trap_q <= wr & misalign;
      if (wr & misalign) trap_pc_q <= pc;
    end
  end

  assign misalign_trap = trap_q;
  assign trap_pc       = trap_pc_q;
`endif

  exmem_skid #(
    .T(exmem_bundle_t)
  ) u_skid (
    .clk_i   (clk),
    .rst_ni  (reset_n),
    .flush_i (flush),
    .wr_i    (wr),
    .data_i  (b_in),
    .ready_o (skid_ready),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (b_out)
  );

  assign out_addr   = b_out.addr;
  assign out_wdata  = b_out.wdata;
  assign out_wb     = b_out.wb;
  assign out_rd     = b_out.rd;
  assign out_ctrl   = b_out.ctrl;
  assign out_funct3 = b_out.funct3;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Bench for ex_mem_stage: scenario tasks plus a negedge scoreboard for the MEM bundle and redirect pulses.
module tb_ex_mem_stage;

  localparam int DW = 32;
  localparam int RW = 5;
  localparam int BW = 3 * DW + RW + 7 + 3;

  logic          clk;
  logic          reset_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] alu_result, pc, imm, rs1_data, rs2_data;
  logic [RW-1:0] rd;
  logic [6:0]    ctrl;
  logic [2:0]    funct3;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_addr, out_wdata, out_wb;
  logic [RW-1:0] out_rd;
  logic [6:0]    out_ctrl;
  logic [2:0]    out_funct3;
  logic          redirect_valid;
  logic [DW-1:0] redirect_pc;
  logic          flush;
`ifdef EXMEM_MISALIGN_TRAP_EN
  logic          misalign_trap;
  logic [DW-1:0] trap_pc;
  logic          exp_trap = 1'b0;
  logic [DW-1:0] exp_trap_pc = '0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [BW-1:0] exp_q[$];
  logic          exp_redir = 1'b0;
  logic [DW-1:0] exp_redir_pc = '0;
  logic          rand_done;

  ex_mem_stage dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .alu_result     (alu_result),
    .pc             (pc),
    .imm            (imm),
    .rs1_data       (rs1_data),
    .rs2_data       (rs2_data),
    .rd             (rd),
    .ctrl           (ctrl),
    .funct3         (funct3),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_addr       (out_addr),
    .out_wdata      (out_wdata),
    .out_wb         (out_wb),
    .out_rd         (out_rd),
    .out_ctrl       (out_ctrl),
    .out_funct3     (out_funct3),
`ifdef EXMEM_MISALIGN_TRAP_EN
    .misalign_trap  (misalign_trap),
    .trap_pc        (trap_pc),
`endif
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .flush          (flush)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [DW-1:0] m_target(input logic [6:0] c, input logic [DW-1:0] p,
                                             input logic [DW-1:0] im, input logic [DW-1:0] r1);
    logic [DW-1:0] t;
    if (c[4]) begin
      t    = r1 + im;
      t[0] = 1'b0;
    end else begin
      t = p + im;
    end
    return t;
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [BW-1:0] exp_b;
    logic [6:0]    c2;
    logic [DW-1:0] tgt, wbv;
    logic          tk, mis, nr;
`ifdef EXMEM_MISALIGN_TRAP_EN
    logic          nt;
    nt = 1'b0;
`endif
    nr = 1'b0;
    if (!reset_n) begin
      exp_q.delete();
      exp_redir = 1'b0;
`ifdef EXMEM_MISALIGN_TRAP_EN
      exp_trap = 1'b0;
`endif
    end else begin
      n_cmp++;
      if (redirect_valid !== exp_redir) begin
        n_err++;
        $display("FAIL redirect_valid: got %b, required %b", redirect_valid, exp_redir);
      end
      if (exp_redir) begin
        n_cmp++;
        if (redirect_pc !== exp_redir_pc) begin
          n_err++;
          $display("FAIL redirect_pc: got %h, required %h", redirect_pc, exp_redir_pc);
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
          n_err++;
          $display("FAIL drop_ready: got %b, required 1", in_ready);
        end
      end
`ifdef EXMEM_MISALIGN_TRAP_EN
      n_cmp++;
      if (misalign_trap !== exp_trap || (exp_trap && trap_pc !== exp_trap_pc)) begin
        n_err++;
        $display("FAIL trap: got %b/%h, required %b/%h", misalign_trap, trap_pc, exp_trap, exp_trap_pc);
      end
`endif
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_out: got addr %h, required no beat", out_addr);
        end else begin
          exp_b = exp_q.pop_front();
          if ({out_addr, out_wdata, out_wb, out_rd, out_ctrl, out_funct3} !== exp_b) begin
            n_err++;
            $display("FAIL out_bundle: got %h, required %h",
                     {out_addr, out_wdata, out_wb, out_rd, out_ctrl, out_funct3}, exp_b);
          end
        end
      end
      if (flush === 1'b1) begin
        exp_q.delete();
      end else if (in_valid === 1'b1 && in_ready === 1'b1 && !exp_redir) begin
        tk  = (ctrl[6] & alu_result[0]) | ctrl[5] | ctrl[4];
        tgt = m_target(ctrl, pc, imm, rs1_data);
        wbv = (ctrl[5] | ctrl[4]) ? pc + 32'd4 : alu_result;
        c2  = ctrl;
        mis = 1'b0;
`ifdef EXMEM_MISALIGN_TRAP_EN
        mis = tk & tgt[1];
        if (mis) begin
          c2[3]       = 1'b0;
          nt          = 1'b1;
          exp_trap_pc = pc;
        end
`endif
        exp_q.push_back({alu_result, rs2_data, wbv, rd, c2, funct3});
        if (tk && !mis) begin
          nr           = 1'b1;
          exp_redir_pc = tgt;
        end
      end
      exp_redir = nr;
`ifdef EXMEM_MISALIGN_TRAP_EN
      exp_trap = nt;
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input logic [6:0] c, input logic [DW-1:0] a, input logic [DW-1:0] p,
                          input logic [DW-1:0] im, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                          input logic [RW-1:0] d, input logic [2:0] f3);
    ctrl = c; alu_result = a; pc = p; imm = im;
    rs1_data = r1; rs2_data = r2; rd = d; funct3 = f3;
    in_valid = 1'b1;
  endtask

  task automatic wait_accept(input string name);
    int k;
    for (k = 0; k < 60; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) break;
    end
    if (k == 60) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_accept: got in_ready %b, required 1 within 60 cycles", name, in_ready);
    end
    step();
  endtask

  task automatic send(input logic [6:0] c, input logic [DW-1:0] a, input logic [DW-1:0] p,
                      input logic [DW-1:0] im, input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                      input logic [RW-1:0] d, input logic [2:0] f3, input string name);
    set_beat(c, a, p, im, r1, r2, d, f3);
    wait_accept(name);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    ctrl     = '0;
  endtask

  task automatic drain(input string name);
    int k;
    out_ready = 1'b1;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0) break;
    end
    step();
    @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL %s_drain: got %0d pending, out_valid %b, required 0 and 0", name, exp_q.size(), out_valid);
    end
    step();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_valid = 1'b0; ctrl = '0; alu_result = '0; pc = '0; imm = '0;
    rs1_data = '0; rs2_data = '0; rd = '0; funct3 = '0;
    repeat (3) step();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctl: got ov %b rv %b ir %b, required 0 0 1", out_valid, redirect_valid, in_ready);
    end
    n_cmp++;
    if (redirect_pc !== '0 || out_addr !== '0 || out_wb !== '0 || out_ctrl !== '0) begin
      n_err++;
      $display("FAIL reset_payload: got rpc %h addr %h wb %h ctrl %h, required 0", redirect_pc, out_addr, out_wb, out_ctrl);
    end
`ifdef EXMEM_MISALIGN_TRAP_EN
    n_cmp++;
    if (misalign_trap !== 1'b0 || trap_pc !== '0) begin
      n_err++;
      $display("FAIL reset_trap: got %b/%h, required 0/0", misalign_trap, trap_pc);
    end
`endif
    @(posedge clk);
    #1 reset_n = 1'b1;
    step();
  endtask

  task automatic test_branch();
    out_ready = 1'b1;
    send(7'b1000000, 32'h1, 32'h100, 32'h20, 32'h0, 32'h55, 5'd0, 3'd0, "beq");
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h120) begin
      n_err++;
      $display("FAIL beq_redirect: got %b/%h, required 1/00000120", redirect_valid, redirect_pc);
    end
    send(7'b0001000, 32'hDEAD_BEEF, 32'h124, 32'h0, 32'h0, 32'h0, 5'd7, 3'd2, "wrong_path");
    send(7'b1000000, 32'h0, 32'h300, 32'h40, 32'h0, 32'h66, 5'd0, 3'd1, "bne_nt");
    idle();
    n_cmp++;
    if (redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL not_taken: got redirect %b, required 0", redirect_valid);
    end
    drain("branch");
  endtask

  task automatic test_jump();
    out_ready = 1'b1;
    send(7'b0011000, 32'hABC, 32'h200, 32'h4, 32'h1003, 32'h0, 5'd1, 3'd0, "jalr");
    idle();
    n_cmp++;
    if (redirect_pc !== 32'h1006 || out_valid !== 1'b1 || out_wb !== 32'h204) begin
      n_err++;
      $display("FAIL jalr: got rpc %h ov %b wb %h, required 00001006 1 00000204", redirect_pc, out_valid, out_wb);
    end
    step();
    step();
    send(7'b0101000, 32'h0, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 5'd2, 3'd0, "jal_wrap");
    idle();
    n_cmp++;
    if (redirect_pc !== 32'h10 || out_wb !== 32'hFFFF_FFF4) begin
      n_err++;
      $display("FAIL jal_wrap: got rpc %h wb %h, required 00000010 fffffff4", redirect_pc, out_wb);
    end
    drain("jump");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(7'b0000110, 32'hA0, 32'h0, 32'h0, 32'h0, 32'hA1, 5'd3, 3'd2, "bp_a");
    send(7'b0000010, 32'hB0, 32'h0, 32'h0, 32'h0, 32'hB1, 5'd4, 3'd1, "bp_b");
    set_beat(7'b0001101, 32'hC0, 32'h0, 32'h0, 32'h0, 32'hC1, 5'd5, 3'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_addr !== 32'hA0) begin
        n_err++;
        $display("FAIL bp_hold%0d: got ir %b ov %b addr %h, required 0 1 000000a0", i, in_ready, out_valid, out_addr);
      end
      step();
    end
    out_ready = 1'b1;
    wait_accept("bp_c");
    idle();
    drain("backpressure");
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    send(7'b0001000, 32'h11, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 3'd0, "fl_a");
    send(7'b0001000, 32'h22, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, "fl_b");
    set_beat(7'b1000000, 32'h1, 32'h400, 32'h8, 32'h0, 32'h0, 5'd0, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_full: got ov %b ir %b rv %b, required 0 1 0", out_valid, in_ready, redirect_valid);
    end
    step();
    set_beat(7'b0100000, 32'h0, 32'h500, 32'h10, 32'h0, 32'h0, 5'd0, 3'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL flush_taken: got rv %b ov %b, required 0 0", redirect_valid, out_valid);
    end
    step();
    send(7'b0100000, 32'h0, 32'h600, 32'h10, 32'h0, 32'h0, 5'd0, 3'd0, "fl_jal");
    idle();
    flush = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h610) begin
      n_err++;
      $display("FAIL flush_live_redirect: got %b/%h, required 1/00000610", redirect_valid, redirect_pc);
    end
    step();
    flush = 1'b0;
    drain("flush");
  endtask

  task automatic test_misalign();
    out_ready = 1'b1;
    send(7'b0101000, 32'h0, 32'h10, 32'h6, 32'h0, 32'h0, 5'd9, 3'd0, "mis_jal");
    idle();
`ifdef EXMEM_MISALIGN_TRAP_EN
    n_cmp++;
    if (misalign_trap !== 1'b1 || trap_pc !== 32'h10 || redirect_valid !== 1'b0 || out_ctrl[3] !== 1'b0) begin
      n_err++;
      $display("FAIL misalign_trap: got trap %b pc %h rv %b rw %b, required 1 00000010 0 0",
               misalign_trap, trap_pc, redirect_valid, out_ctrl[3]);
    end
`else
    n_cmp++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h16) begin
      n_err++;
      $display("FAIL misalign_redirect: got %b/%h, required 1/00000016", redirect_valid, redirect_pc);
    end
`endif
    drain("misalign");
  endtask

  task automatic test_back_to_back();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          send(7'($urandom_range(0, 127)), $urandom, $urandom, $urandom, $urandom, $urandom,
               5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), "b2b");
        end
        idle();
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          step();
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain("back_to_back");
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    send(7'b0001000, 32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 3'd0, "rm_a");
    send(7'b0001000, 32'h88, 32'h0, 32'h0, 32'h0, 32'h0, 5'd2, 3'd0, "rm_b");
    idle();
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL rm_full: got in_ready %b, required 0", in_ready);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || redirect_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_async: got ov %b rv %b, required 0 0", out_valid, redirect_valid);
    end
    @(negedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rm_release: got ir %b ov %b, required 1 0", in_ready, out_valid);
    end
    step();
    out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_branch();
    test_jump();
    test_backpressure();
    test_flush();
    test_misalign();
    test_back_to_back();
    test_reset_midstream();
    repeat (2) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Sits directly downstream of the ALU and consumes its ALUResult.
- Resolves branches and jumps: taken/not-taken decision and target address. Issues a registered redirect to fetch.
- Selects the writeback value (pc+4 for jumps) and holds the EX/MEM bundle in a 2-entry skid buffer with a valid/ready handshake toward MEM.

Parameters:
- DATA_WIDTH, 32, width of data, pc and imm.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- in_valid  in  1  EX result valid
- in_ready  out  1  stage can accept
- alu_result  in  DATA_WIDTH  ALUResult from the ALU
- pc  in  DATA_WIDTH  instruction pc
- imm  in  DATA_WIDTH  sign-extended immediate
- rs1_data  in  DATA_WIDTH  forwarded rs1 (jalr base)
- rs2_data  in  DATA_WIDTH  forwarded rs2 (store data)
- rd  in  REG_ADDR_W  destination register
- ctrl  in  7  {branch, jal, jalr, reg_write, mem_read, mem_write, mem_to_reg}
- funct3  in  3  memory access size
- out_valid  out  1  MEM bundle valid
- out_ready  in  1  MEM accepts
- out_addr  out  DATA_WIDTH  alu_result (memory address)
- out_wdata  out  DATA_WIDTH  rs2_data
- out_wb  out  DATA_WIDTH  writeback value
- out_rd, out_ctrl, out_funct3  out  as inputs  registered copies
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  DATA_WIDTH  new fetch pc
- flush  in  1  synchronous kill from a later stage

Behaviour:
- Reset (async, reset_n=0): out_valid=0, redirect_valid=0, redirect_pc=0, both buffer entries invalid, in_ready=1. All payload registers are cleared to 0.
- taken = (branch & alu_result[0]) | jal | jalr.
- target:
  - jalr: (rs1_data + imm) & ~1.
  - otherwise: pc + imm.
  - Both are computed mod 2^DATA_WIDTH; wrap-around is silent.
- wb value = (jal | jalr) ? pc + 4 : alu_result.
- Accept occurs when in_valid & in_ready.
  - On accept with taken=1: redirect_valid=1 and redirect_pc=target on the next cycle, for exactly one cycle.
- Wrong-path drop: while redirect_valid=1, in_ready is forced to 1. Any in_valid beat that cycle is consumed and discarded: no buffer write, no redirect.
- Skid buffer (main + skid entry):
  - Latency is 1 cycle from accept to out_valid when the buffer is empty.
  - in_ready = !skid_valid (registered), except for the forced-1 drop case above.
  - If main is valid and out_ready=0 when a beat is accepted, the beat goes to skid.
  - When main is consumed, skid moves to main.
  - Simultaneous accept and consume with only main valid: the new beat overwrites main and out_valid stays 1.
  - Full (both entries valid): in_ready=0. The input is held upstream; no loss.
  - Output payload is stable while out_valid & !out_ready.
- flush=1 (synchronous):
  - Invalidates both entries and drops any beat presented that cycle.
  - Suppresses a redirect that would be generated that cycle.
  - A redirect_valid already asserted still completes its single cycle.
- Not-taken branches write nothing (reg_write=0 from decode) and pass through for pipeline accounting.

Optional Feature:
- Macro EXMEM_MISALIGN_TRAP_EN.
- When defined:
  - A taken target with target[1]=1 does not redirect.
  - Adds output misalign_trap (1 bit, reset 0), pulsed one cycle after accept, with trap_pc=pc (DATA_WIDTH, reset 0).
  - The bundle is passed with reg_write cleared.
- When undefined: no extra ports; misaligned targets redirect normally.

Decomposition:
- Package ex_mem_pkg:
  - ctrl_t packed struct (the 7 control bits in port order).
  - exmem_bundle_t struct (addr, wdata, wb, rd, ctrl, funct3).
  - Constant REDIRECT_ALIGN_MASK.
- Sub-module exmem_skid: generic 2-entry skid buffer parameterised on the bundle type.
- Branch resolution stays inline in ex_mem_stage.

Test Plan:
- Reset mid-stream: both entries full, assert reset_n=0 -> out_valid=0, redirect_valid=0 immediately; in_ready=1 after release.
- BEQ taken: branch=1, alu_result=1, pc=0x100, imm=0x20 -> next cycle redirect_valid=1, redirect_pc=0x120; next in_valid beat is dropped.
- JALR: rs1_data=0x1003, imm=0x4, pc=0x200 -> redirect_pc=0x1006; out_wb=0x204.
- Backpressure: out_ready=0 for 3 cycles while presenting beats A,B,C -> A in main, B in skid, in_ready=0, C held. After out_ready=1, outputs are A,B,C in order with no duplicates.
- Flush with full buffer plus a taken branch at input -> both entries invalid next cycle, no redirect pulse.
- With EXMEM_MISALIGN_TRAP_EN: jal pc=0x10, imm=0x6 -> misalign_trap=1, trap_pc=0x10, redirect_valid=0, bundle out_ctrl.reg_write=0.
